// File: rtl/lms_serial_filter_pkg.sv
// Shared types and saturation helpers for the serial LMS adaptive filter.
package lms_pkg;

  typedef enum logic [1:0] {
    LMS       = 2'd0,
    SIGN_ERR  = 2'd1,
    SIGN_SIGN = 2'd2
  } lms_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    ERR  = 2'd2,
    UPD  = 2'd3
  } lms_state_t;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Saturate to the sample width (data_out / err_out).
  function automatic logic signed [63:0] sat_dat(input logic signed [63:0] v,
                                                 input int dat_w);
    return sat_w(v, dat_w);
  endfunction

  // Saturate to the coefficient width.
  function automatic logic signed [63:0] sat_coef(input logic signed [63:0] v,
                                                  input int coef_w);
    return sat_w(v, coef_w);
  endfunction

endpackage

// File: rtl/lms_serial_filter_update.sv
// Per-tap coefficient update: forms the mode-dependent product, scales it by
// the step size and saturates the new coefficient. Purely combinational.
module lms_update_unit
  import lms_pkg::*;
#(
  parameter int DAT_W  = 16,
  parameter int COEF_W = 24
) (
  input  logic signed [COEF_W-1:0] w_in,
  input  logic signed [DAT_W-1:0]  e_in,
  input  logic signed [DAT_W-1:0]  x_in,
  input  logic [1:0]               mode,
  input  logic [4:0]               mu_shift,
  output logic signed [COEF_W-1:0] w_out
);

  // Product e*x sits at 2*DAT_W-2 fractional bits, coefficients at COEF_W-2.
  localparam int BASE_SH = 2 * DAT_W - COEF_W;

  logic signed [63:0] e_ext;
  logic signed [63:0] x_ext;
  logic signed [63:0] w_ext;
  logic signed [63:0] sgn_e;
  logic signed [63:0] sgn_x;
  logic signed [63:0] p;
  logic signed [63:0] delta;
  logic signed [63:0] w_sum;
  int                 sh;

  // Compute the updated coefficient for one tap.
  always_comb begin
    e_ext = {{(64 - DAT_W){e_in[DAT_W-1]}}, e_in};
    x_ext = {{(64 - DAT_W){x_in[DAT_W-1]}}, x_in};
    w_ext = {{(64 - COEF_W){w_in[COEF_W-1]}}, w_in};
    sgn_e = (e_in == '0) ? 64'sd0 : (e_in[DAT_W-1] ? -64'sd1 : 64'sd1);
    sgn_x = (x_in == '0) ? 64'sd0 : (x_in[DAT_W-1] ? -64'sd1 : 64'sd1);
    case (mode)
      SIGN_ERR:  p = (sgn_e * x_ext) <<< (DAT_W - 1);
      SIGN_SIGN: p = (sgn_e * sgn_x) <<< (2 * DAT_W - 2);
      default:   p = e_ext * x_ext;
    endcase
    sh    = BASE_SH + int'(mu_shift);
    delta = p >>> sh;
    w_sum = w_ext + delta;
    w_out = COEF_W'(sat_coef(w_sum, COEF_W));
  end

endmodule

// File: rtl/lms_serial_filter.sv
// Time-multiplexed adaptive FIR: one shared multiplier walks TAP taps to
// filter, then TAP taps to adapt the coefficients.
//
// state | meaning
// IDLE  | waiting for a sample or a coefficient clear, in_ready high
// FILT  | accumulating w[k]*x[k], one tap per cycle
// ERR   | output y and e registered, out_valid pulsed
// UPD   | coefficient update, one tap per cycle (only if adapt latched)
module lms_serial_filter
  import lms_pkg::*;
#(
  parameter int DAT_W  = 16,
  parameter int COEF_W = 24,
  parameter int TAP    = 63,
  parameter int ACC_W  = DAT_W + COEF_W + $clog2(TAP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DAT_W-1:0] data_in,
  input  logic [DAT_W-1:0] ref_in,
  input  logic [4:0]       mu_shift,
  input  logic [1:0]       mode,
  input  logic             adapt_en,
  input  logic             coef_clr,
  output logic             out_valid,
  output logic [DAT_W-1:0] data_out,
  output logic [DAT_W-1:0] err_out
);

  localparam int             K_W    = $clog2(TAP);
  localparam logic [K_W-1:0] K_LAST = K_W'(TAP - 1);

  lms_state_t               state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [COEF_W-1:0] w_q [TAP];
  logic signed [COEF_W-1:0] w_d [TAP];
  logic signed [DAT_W-1:0]  x_q [TAP];
  logic signed [DAT_W-1:0]  x_d [TAP];
  logic signed [DAT_W-1:0]  ref_q, ref_d;
  logic [4:0]               mu_q, mu_d;
  logic [1:0]               mode_q, mode_d;
  logic                     adapt_q, adapt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DAT_W-1:0]  data_out_q, data_out_d;
  logic signed [DAT_W-1:0]  err_out_q, err_out_d;

  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [63:0]       acc_wide;
  logic signed [63:0]       y_wide;
  logic signed [63:0]       d_wide;
  logic signed [DAT_W-1:0]  y_val;
  logic signed [DAT_W-1:0]  e_val;
  logic signed [COEF_W-1:0] w_new;

  // The error used during UPD is the registered err_out, stable for the
  // whole update pass.
  lms_update_unit #(
    .DAT_W  (DAT_W),
    .COEF_W (COEF_W)
  ) u_update (
    .w_in     (w_q[k_q]),
    .e_in     (err_out_q),
    .x_in     (x_q[k_q]),
    .mode     (mode_q),
    .mu_shift (mu_q),
    .w_out    (w_new)
  );

  // Shared tap multiply and the output/error arithmetic used in ERR.
  always_comb begin
    w_ext    = {{(ACC_W - COEF_W){w_q[k_q][COEF_W-1]}}, w_q[k_q]};
    x_ext    = {{(ACC_W - DAT_W){x_q[k_q][DAT_W-1]}}, x_q[k_q]};
    prod     = w_ext * x_ext;
    acc_wide = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    y_val    = DAT_W'(sat_dat(acc_wide >>> (COEF_W - 2), DAT_W));
    y_wide   = {{(64 - DAT_W){y_val[DAT_W-1]}}, y_val};
    d_wide   = {{(64 - DAT_W){ref_q[DAT_W-1]}}, ref_q};
    e_val    = DAT_W'(sat_dat(d_wide - y_wide, DAT_W));
  end

  // Next-state logic: the tap counter runs down to zero as its terminal count.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    w_d         = w_q;
    x_d         = x_q;
    ref_d       = ref_q;
    mu_d        = mu_q;
    mode_d      = mode_q;
    adapt_d     = adapt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    err_out_d   = err_out_q;
    case (state_q)
      IDLE: begin
        if (coef_clr) begin
          for (int i = 0; i < TAP; i++) begin
            w_d[i] = '0;
            x_d[i] = '0;
          end
          in_ready_d = 1'b0;
        end else if (in_valid && in_ready_q) begin
          x_d[0] = data_in;
          for (int i = 1; i < TAP; i++) x_d[i] = x_q[i-1];
          ref_d      = ref_in;
          mu_d       = mu_shift;
          mode_d     = mode;
          adapt_d    = adapt_en;
          acc_d      = '0;
          k_d        = K_LAST;
          in_ready_d = 1'b0;
          state_d    = FILT;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      FILT: begin
        acc_d = acc_q + prod;
        if (k_q == '0) state_d = ERR;
        else           k_d = k_q - K_W'(1);
      end
      ERR: begin
        data_out_d  = y_val;
        err_out_d   = e_val;
        out_valid_d = 1'b1;
        if (adapt_q) begin
          k_d     = K_LAST;
          state_d = UPD;
        end else begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      UPD: begin
        w_d[k_q] = w_new;
        if (k_q == '0) begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs registered; reset aborts any sample in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < TAP; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      ref_q       <= '0;
      mu_q        <= '0;
      mode_q      <= '0;
      adapt_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      err_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      x_q         <= x_d;
      ref_q       <= ref_d;
      mu_q        <= mu_d;
      mode_q      <= mode_d;
      adapt_q     <= adapt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      err_out_q   <= err_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign err_out   = err_out_q;

endmodule

// File: tb/tb_lms_serial_filter.sv
// Directed plus randomized bench for lms_serial_filter with TAP=4, checked
// against a plain-arithmetic LMS reference model.
module tb_lms_serial_filter;

  localparam int TAP = 4;
  localparam int DW  = 16;
  localparam int CW  = 24;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic [DW-1:0] ref_in   = '0;
  logic [4:0]    mu_shift = '0;
  logic [1:0]    mode     = '0;
  logic          adapt_en = 1'b0;
  logic          coef_clr = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic [DW-1:0] err_out;

  lms_serial_filter #(.DAT_W(DW), .COEF_W(CW), .TAP(TAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .ref_in(ref_in), .mu_shift(mu_shift), .mode(mode),
    .adapt_en(adapt_en), .coef_clr(coef_clr), .out_valid(out_valid),
    .data_out(data_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     acc_cyc  = 0;
  int     last_acc = 0;
  int     period   = 0;
  int     lat      = 0;
  longint ey, ee;
  longint mw [TAP];
  longint mx [TAP];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint sgn(input longint v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic longint rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return longint'(t);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAP; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
  endtask

  task automatic model_step(input longint din, input longint dref, input int mu,
                            input int md, input bit ad,
                            output longint y, output longint e);
    longint acc, p;
    for (int k = TAP - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = din;
    acc = 0;
    for (int k = 0; k < TAP; k++) acc += mw[k] * mx[k];
    y = sat(acc >>> (CW - 2), DW);
    e = sat(dref - y, DW);
    if (ad) begin
      for (int k = 0; k < TAP; k++) begin
        if (md == 1)      p = sgn(e) * mx[k] * (64'sd1 <<< (DW - 1));
        else if (md == 2) p = sgn(e) * sgn(mx[k]) * (64'sd1 <<< (2 * DW - 2));
        else              p = e * mx[k];
        mw[k] = sat(mw[k] + (p >>> (2 * DW - CW + mu)), CW);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready_wait"}, longint'(n < 60), 1);
  endtask

  task automatic send(input longint din, input longint dref, input int mu,
                      input int md, input bit ad, input string tag);
    int     n;
    longint y, e;
    wait_ready(tag);
    data_in  = din[DW-1:0];
    ref_in   = dref[DW-1:0];
    mu_shift = mu[4:0];
    mode     = md[1:0];
    adapt_en = ad;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    period   = acc_cyc - last_acc;
    last_acc = acc_cyc;
    in_valid = 1'b0;
    data_in  = DW'($urandom);
    ref_in   = DW'($urandom);
    mu_shift = 5'($urandom);
    mode     = 2'($urandom);
    adapt_en = 1'($urandom);
    model_step(din, dref, mu, md, ad, y, e);
    ey = y;
    ee = e;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    lat = cyc - acc_cyc;
    chk({tag, "_latency"}, lat, TAP + 1);
    chk({tag, "_data_out"}, $signed(data_out), ey);
    chk({tag, "_err_out"}, $signed(err_out), ee);
  endtask

  task automatic check_w(input string tag);
    for (int i = 0; i < TAP; i++)
      chk($sformatf("%s_w%0d", tag, i), dut.w_q[i], mw[i]);
  endtask

  task automatic check_x_zero(input string tag);
    for (int i = 0; i < TAP; i++)
      chk($sformatf("%s_x%0d", tag, i), dut.x_q[i], 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int     ov_cnt;
    longint a, d;

    // Reset held with random inputs
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom); coef_clr = 1'($urandom); adapt_en = 1'($urandom);
      data_in  = DW'($urandom); ref_in = DW'($urandom);
      mode     = 2'($urandom); mu_shift = 5'($urandom);
    end
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err_out", err_out, 0);
    in_valid = 1'b0;
    coef_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rdy_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_ready, 1);
    model_clear();

    // Zero weights, no adaptation
    send(1000, 2000, 0, 0, 0, "zero");
    chk("zero_y_const", $signed(data_out), 0);
    chk("zero_e_const", $signed(err_out), 2000);
    send(rnd16(), rnd16(), 0, 0, 0, "zero2");
    chk("period_noadapt", period, TAP + 2);

    // Clear coefficients and delay line from IDLE
    coef_clr = 1'b1;
    @(posedge clk); #1;
    coef_clr = 1'b0;
    chk("clr_in_ready", in_ready, 0);
    model_clear();
    check_x_zero("clr");
    check_w("clr");

    // Sign-sign adaptation
    send(500, 300, 0, 2, 1, "ss1");
    wait_ready("ss1_upd");
    chk("ss1_w0_const", dut.w_q[0], 4194304);
    check_w("ss1");
    send(1000, 0, 0, 2, 0, "ss2");
    chk("ss_period_adapt", period, 2 * TAP + 2);
    chk("ss2_y_const", $signed(data_out), 1000);
    chk("ss2_e_const", $signed(err_out), -1000);
    @(posedge clk); #1;
    chk("out_valid_pulse", out_valid, 0);
    send(rnd16(), rnd16(), 3, 2, 1, "ss3");
    send(rnd16(), rnd16(), 3, 2, 1, "ss4");
    chk("b2b_adapt_period", period, 2 * TAP + 2);
    wait_ready("ss4_upd");
    check_w("ss4");

    // coef_clr during UPD is deferred until IDLE
    send(rnd16(), rnd16(), 4, 0, 1, "cu");
    coef_clr = 1'b1;
    wait_ready("cu_upd");
    check_w("cu_before_clr");
    @(posedge clk); #1;
    coef_clr = 1'b0;
    chk("cu_in_ready", in_ready, 0);
    model_clear();
    check_w("cu_after_clr");
    check_x_zero("cu_after_clr");

    // Coefficient and output saturation
    send(500, 300, 0, 2, 1, "sat1");
    wait_ready("sat1_upd");
    chk("sat1_w0_const", dut.w_q[0], 4194304);
    send(20000, 32767, 0, 2, 1, "sat2");
    wait_ready("sat2_upd");
    chk("sat2_w0_const", dut.w_q[0], 8388607);
    send(30000, 0, 0, 2, 0, "sat3");
    chk("sat3_y_const", $signed(data_out), 32767);
    chk("sat3_e_const", $signed(err_out), -32767);
    send(100, 32767, 0, 2, 1, "sat4");
    wait_ready("sat4_upd");
    chk("sat4_w0_const", dut.w_q[0], 8388607);
    check_w("sat4");

    // Reset pulsed during FILT
    data_in = DW'($urandom); ref_in = DW'($urandom);
    mode = 2'd0; mu_shift = 5'd2; adapt_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    ov_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ov_cnt++;
    end
    chk("midrst_no_out_valid", ov_cnt, 0);
    chk("midrst_ready_back", in_ready, 1);
    model_clear();
    check_w("midrst");
    check_x_zero("midrst");
    send(rnd16(), rnd16(), 5, 0, 1, "midrst_resume");

    // Clear, then LMS convergence on an identity system
    wait_ready("conv_pre");
    coef_clr = 1'b1;
    @(posedge clk); #1;
    coef_clr = 1'b0;
    model_clear();
    for (int i = 0; i < 2000; i++) begin
      d = rnd16();
      send(d, d, 2, 0, 1, "lms");
      if (i >= 1900) begin
        a = ee < 0 ? -ee : ee;
        a = $signed(err_out);
        if (a < 0) a = -a;
        chk($sformatf("lms_conv_%0d", i), longint'(a < 8), 1);
      end
    end
    wait_ready("lms_end");
    check_w("lms_end");

    // Random modes, step sizes and adapt flags
    for (int i = 0; i < 60; i++) begin
      send(rnd16(), rnd16(), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 3)), 1'($urandom), "rnd");
    end
    wait_ready("rnd_end");
    check_w("rnd_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
